vram_oam_responder: RTL and testbench

Memory-side responder for the PPU's VRAM/OAM fetch port and the CPU's video-memory accesses. Holds 8 KiB VRAM (0x8000–0x9FFF) and 160 B OAM (0xFE00–0xFE9F) as dual-port RAM. Enforces mode-based CPU lockout from the PPU's PPU_MODE and runs the OAM DMA engine triggered by CPU writes to 0xFF46. Sits between the CPU bus decoder and the PPU, which is the initiator on the PPU port.

---
 rtl/vram_oam_responder.sv | 178 +++++++++++++++++
 tb/tb_vram_oam_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_oam_responder.sv
// VRAM/OAM store shared by the CPU bus and the PPU fetch port, with CPU lockout by PPU mode.
// Define OAM_DMA_EN to build the OAM DMA engine triggered by CPU writes to 0xFF46.
module vram_oam_responder #(
  parameter int VRAM_AW   = 13,
  parameter int OAM_BYTES = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] CPU_ADDR,
  input  logic        CPU_WR,
  input  logic        CPU_RD,
  input  logic [7:0]  CPU_DATA_out,
  output logic [7:0]  CPU_DATA_in,
  input  logic        LCD_EN,
  input  logic [1:0]  PPU_MODE,
  input  logic        PPU_RD,
  input  logic [15:0] PPU_ADDR,
  output logic [7:0]  PPU_DATA,
  output logic        DMA_BUS_RD,
  output logic [15:0] DMA_BUS_ADDR,
  input  logic [7:0]  DMA_BUS_DATA,
  output logic        DMA_ACTIVE
);

  localparam int                OAM_IW       = $clog2(OAM_BYTES);
  localparam logic [7:0]        OAM_TOP      = 8'(OAM_BYTES - 1);
  localparam logic [OAM_IW-1:0] OAM_LAST_IDX = OAM_IW'(OAM_BYTES - 1);

  logic [7:0] vram [0:(2**VRAM_AW)-1];
  logic [7:0] oam  [0:OAM_BYTES-1];

  function automatic logic is_vram(input logic [15:0] a);
    return a[15:13] == 3'b100;
  endfunction

  function automatic logic is_oam(input logic [15:0] a);
    return (a[15:8] == 8'hFE) && (a[7:0] <= OAM_TOP);
  endfunction

  function automatic logic is_oam_gap(input logic [15:0] a);
    return (a[15:8] == 8'hFE) && (a[7:0] > OAM_TOP);
  endfunction

  logic              dma_active;
  logic              dma_we_p0;
  logic [OAM_IW-1:0] dma_widx_p0;

  logic              vram_lock_p0, oam_lock_p0;
  logic              cpu_vram_we_p0, cpu_oam_we_p0, oam_we_p0;
  logic [OAM_IW-1:0] oam_widx_p0;
  logic [7:0]        oam_wdata_p0;
  logic [7:0]        cpu_rdata_p0, ppu_rdata_p0;
  logic              cpu_vld_p0, ppu_vld_p0;
  logic [7:0]        cpu_data_p1, ppu_data_p1;

`ifdef OAM_DMA_EN
  typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_XFER, DMA_LAST} dma_state_t;

  dma_state_t        dma_state;
  logic [OAM_IW-1:0] dma_idx;
  logic [7:0]        dma_src_hi;
  logic              dma_bus_rd;
  logic [15:0]       dma_bus_addr;
  logic              dma_trig_p0;

  assign dma_trig_p0 = CPU_WR && (CPU_ADDR == 16'hFF46);

  // A 0xFF46 write restarts from START in any state; bytes already copied are left in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_state    <= DMA_IDLE;
      dma_idx      <= '0;
      dma_src_hi   <= '0;
      dma_active   <= 1'b0;
      dma_bus_rd   <= 1'b0;
      dma_bus_addr <= '0;
    end else if (dma_trig_p0) begin
      dma_state  <= DMA_START;
      dma_idx    <= '0;
      dma_src_hi <= CPU_DATA_out;
      dma_active <= 1'b1;
      dma_bus_rd <= 1'b0;
    end else begin
      case (dma_state)
        DMA_START: begin
          dma_state    <= DMA_XFER;
          dma_bus_rd   <= 1'b1;
          dma_bus_addr <= {dma_src_hi, 8'h00};
        end
        DMA_XFER: begin
          if (dma_idx == OAM_LAST_IDX) begin
            dma_state  <= DMA_LAST;
            dma_bus_rd <= 1'b0;
          end else begin
            dma_idx      <= dma_idx + OAM_IW'(1);
            dma_bus_addr <= dma_bus_addr + 16'd1;
          end
        end
        DMA_LAST: begin
          dma_state  <= DMA_IDLE;
          dma_active <= 1'b0;
          dma_idx    <= '0;
        end
        default: ;
      endcase
    end
  end

  // Bus data lags the request by one cycle, so each XFER cycle stores the previous index.
  assign dma_we_p0   = !rst && (((dma_state == DMA_XFER) && (dma_idx != '0)) ||
                                (dma_state == DMA_LAST));
  assign dma_widx_p0 = (dma_state == DMA_LAST) ? OAM_LAST_IDX : dma_idx - OAM_IW'(1);

  assign DMA_ACTIVE   = dma_active;
  assign DMA_BUS_RD   = dma_bus_rd;
  assign DMA_BUS_ADDR = dma_bus_addr;
`else
  assign dma_active   = 1'b0;
  assign dma_we_p0    = 1'b0;
  assign dma_widx_p0  = '0;
  assign DMA_ACTIVE   = 1'b0;
  assign DMA_BUS_RD   = 1'b0;
  assign DMA_BUS_ADDR = '0;
`endif

  // Stage p0: decode, lockout and RAM access from this cycle's inputs.
  assign vram_lock_p0 = LCD_EN && (PPU_MODE == 2'd3);
  assign oam_lock_p0  = (LCD_EN && PPU_MODE[1]) || dma_active;

  assign cpu_vram_we_p0 = CPU_WR && is_vram(CPU_ADDR) && !vram_lock_p0;
  assign cpu_oam_we_p0  = CPU_WR && is_oam(CPU_ADDR) && !oam_lock_p0;
  assign oam_we_p0      = dma_we_p0 || cpu_oam_we_p0;
  assign oam_widx_p0    = dma_we_p0 ? dma_widx_p0 : CPU_ADDR[OAM_IW-1:0];
  assign oam_wdata_p0   = dma_we_p0 ? DMA_BUS_DATA : CPU_DATA_out;

  assign cpu_vld_p0 = CPU_RD;
  assign ppu_vld_p0 = PPU_RD || PPU_MODE[1];

  always_ff @(posedge clk) begin
    if (cpu_vram_we_p0) vram[CPU_ADDR[VRAM_AW-1:0]] <= CPU_DATA_out;
    if (oam_we_p0)      oam[oam_widx_p0]            <= oam_wdata_p0;
  end

  always_comb begin
    cpu_rdata_p0 = 8'hFF;
    if (is_vram(CPU_ADDR))
      cpu_rdata_p0 = vram_lock_p0 ? 8'hFF : vram[CPU_ADDR[VRAM_AW-1:0]];
    else if (is_oam(CPU_ADDR))
      cpu_rdata_p0 = oam_lock_p0 ? 8'hFF : oam[CPU_ADDR[OAM_IW-1:0]];
    else if (is_oam_gap(CPU_ADDR))
      cpu_rdata_p0 = 8'h00;
  end

  always_comb begin
    ppu_rdata_p0 = 8'hFF;
    if (is_vram(PPU_ADDR))
      ppu_rdata_p0 = vram[PPU_ADDR[VRAM_AW-1:0]];
    else if (is_oam(PPU_ADDR))
      ppu_rdata_p0 = dma_active ? 8'hFF : oam[PPU_ADDR[OAM_IW-1:0]];
    else if (is_oam_gap(PPU_ADDR))
      ppu_rdata_p0 = 8'h00;
  end

  // Stage p1: registered read data, held between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_data_p1 <= 8'hFF;
      ppu_data_p1 <= 8'hFF;
    end else begin
      if (cpu_vld_p0) cpu_data_p1 <= cpu_rdata_p0;
      if (ppu_vld_p0) ppu_data_p1 <= ppu_rdata_p0;
    end
  end

  assign CPU_DATA_in = cpu_data_p1;
  assign PPU_DATA    = ppu_data_p1;

endmodule

// File: tb/tb_vram_oam_responder.sv
// Directed bench for vram_oam_responder: cycle-level reference model plus literal spot checks.
module tb_vram_oam_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] CPU_ADDR;
  logic        CPU_WR, CPU_RD;
  logic [7:0]  CPU_DATA_out, CPU_DATA_in;
  logic        LCD_EN;
  logic [1:0]  PPU_MODE;
  logic        PPU_RD;
  logic [15:0] PPU_ADDR;
  logic [7:0]  PPU_DATA;
  logic        DMA_BUS_RD;
  logic [15:0] DMA_BUS_ADDR;
  logic [7:0]  DMA_BUS_DATA;
  logic        DMA_ACTIVE;

  always #5 clk = ~clk;

  vram_oam_responder dut (
    .clk(clk), .rst(rst),
    .CPU_ADDR(CPU_ADDR), .CPU_WR(CPU_WR), .CPU_RD(CPU_RD),
    .CPU_DATA_out(CPU_DATA_out), .CPU_DATA_in(CPU_DATA_in),
    .LCD_EN(LCD_EN), .PPU_MODE(PPU_MODE),
    .PPU_RD(PPU_RD), .PPU_ADDR(PPU_ADDR), .PPU_DATA(PPU_DATA),
    .DMA_BUS_RD(DMA_BUS_RD), .DMA_BUS_ADDR(DMA_BUS_ADDR),
    .DMA_BUS_DATA(DMA_BUS_DATA), .DMA_ACTIVE(DMA_ACTIVE)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // System bus: answers one cycle after the request with a function of the address.
  logic bus_mix = 1'b0;
  function automatic logic [7:0] bus_fn(input logic [15:0] a);
    return bus_mix ? (a[7:0] ^ a[15:8]) : (a[7:0] ^ 8'h3C);
  endfunction
  always @(posedge clk) DMA_BUS_DATA <= bus_fn(DMA_BUS_ADDR);

  // Reference model: memories as arrays, DMA as a cycle count t since the trigger
  // (t=0 START, t=1..160 bus reads of src+t-1, t=2..161 store byte t-2 into OAM).
  logic [7:0]  vram_m [0:8191];
  logic [7:0]  oam_m  [0:159];
  int          dma_t = -1;
  logic [15:0] src_m = 16'h0000;
  logic [7:0]  exp_cpu, exp_ppu;
  logic        exp_act = 1'b0, exp_rd = 1'b0;
  logic [15:0] exp_addr = 16'h0000;

  function automatic logic [7:0] read_m(input logic [15:0] a, input logic cpu, input logic act);
    if (a >= 16'h8000 && a <= 16'h9FFF)
      return (cpu && LCD_EN && PPU_MODE == 2'd3) ? 8'hFF : vram_m[a - 16'h8000];
    if (a >= 16'hFE00 && a <= 16'hFE9F)
      return (act || (cpu && LCD_EN && PPU_MODE >= 2'd2)) ? 8'hFF : oam_m[a - 16'hFE00];
    if (a >= 16'hFEA0 && a <= 16'hFEFF)
      return 8'h00;
    return 8'hFF;
  endfunction

  always @(posedge clk) begin : model_step
    logic act;
    if (rst) begin
      exp_cpu  = 8'hFF;
      exp_ppu  = 8'hFF;
      dma_t    = -1;
      exp_addr = 16'h0000;
    end else begin
      act = (dma_t >= 0);
      if (CPU_RD) exp_cpu = read_m(CPU_ADDR, 1'b1, act);
      if (PPU_RD || PPU_MODE >= 2'd2) exp_ppu = read_m(PPU_ADDR, 1'b0, act);
      if (CPU_WR && CPU_ADDR >= 16'h8000 && CPU_ADDR <= 16'h9FFF && !(LCD_EN && PPU_MODE == 2'd3))
        vram_m[CPU_ADDR - 16'h8000] = CPU_DATA_out;
      if (CPU_WR && CPU_ADDR >= 16'hFE00 && CPU_ADDR <= 16'hFE9F && !act &&
          !(LCD_EN && PPU_MODE >= 2'd2))
        oam_m[CPU_ADDR - 16'hFE00] = CPU_DATA_out;
      if (dma_t >= 2) oam_m[dma_t - 2] = bus_fn(16'(src_m + 16'(dma_t - 2)));
`ifdef OAM_DMA_EN
      if (CPU_WR && CPU_ADDR == 16'hFF46) begin
        src_m = {CPU_DATA_out, 8'h00};
        dma_t = 0;
      end else if (dma_t >= 0) begin
        dma_t = (dma_t == 161) ? -1 : dma_t + 1;
      end
`endif
    end
    exp_act = (dma_t >= 0);
    exp_rd  = (dma_t >= 1) && (dma_t <= 160);
    if (exp_rd) exp_addr = 16'(src_m + 16'(dma_t - 1));
  end

  logic checking = 1'b0;
  always @(negedge clk) begin
    if (checking) begin
      check("cyc_cpu_data", 16'(CPU_DATA_in), 16'(exp_cpu));
      check("cyc_ppu_data", 16'(PPU_DATA), 16'(exp_ppu));
      check("cyc_dma_active", 16'(DMA_ACTIVE), 16'(exp_act));
      check("cyc_dma_bus_rd", 16'(DMA_BUS_RD), 16'(exp_rd));
      if (exp_rd) check("cyc_dma_bus_addr", DMA_BUS_ADDR, exp_addr);
    end
  end

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    CPU_ADDR = a; CPU_DATA_out = d; CPU_WR = 1'b1;
    @(negedge clk);
    CPU_WR = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
    CPU_ADDR = a; CPU_RD = 1'b1;
    @(negedge clk);
    CPU_RD = 1'b0;
    d = CPU_DATA_in;
  endtask

  task automatic ppu_rd(input logic [15:0] a, output logic [7:0] d);
    PPU_ADDR = a; PPU_RD = 1'b1;
    @(negedge clk);
    PPU_RD = 1'b0;
    d = PPU_DATA;
  endtask

  // Called in the cycle right after a trigger; returns at the first cycle with DMA_ACTIVE low.
  task automatic run_dma(output int n, output int rds, output logic [15:0] first, output logic [15:0] last);
    n = 0; rds = 0; first = 16'h0; last = 16'h0;
    for (int i = 0; i < 400; i++) begin
      if (!DMA_ACTIVE) break;
      n++;
      if (DMA_BUS_RD) begin
        if (rds == 0) first = DMA_BUS_ADDR;
        last = DMA_BUS_ADDR;
        rds++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0]  d;
    int          n, rds;
    logic [15:0] first, last;

    rst = 1'b1; CPU_ADDR = 16'h0; CPU_WR = 1'b0; CPU_RD = 1'b0; CPU_DATA_out = 8'h0;
    LCD_EN = 1'b0; PPU_MODE = 2'd0; PPU_RD = 1'b0; PPU_ADDR = 16'h0000;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    check("rst_cpu_data", 16'(CPU_DATA_in), 16'hFF);
    check("rst_ppu_data", 16'(PPU_DATA), 16'hFF);
    check("rst_dma_active", 16'(DMA_ACTIVE), 16'h0);
    check("rst_dma_bus_rd", 16'(DMA_BUS_RD), 16'h0);
    check("rst_dma_bus_addr", DMA_BUS_ADDR, 16'h0);
    rst = 1'b0;

    LCD_EN = 1'b1; PPU_MODE = 2'd0;
    cpu_wr(16'h8010, 8'hA5);
    ppu_rd(16'h8010, d);
    check("ppu_vram_8010", 16'(d), 16'hA5);

    cpu_wr(16'h9800, 8'h77);
    PPU_MODE = 2'd3;
    cpu_rd(16'h9800, d);
    check("cpu_vram_locked_draw", 16'(d), 16'hFF);
    cpu_wr(16'h8010, 8'h11);
    LCD_EN = 1'b0;
    cpu_rd(16'h9800, d);
    check("cpu_vram_lcd_off", 16'(d), 16'h77);
    LCD_EN = 1'b1; PPU_MODE = 2'd0;
    cpu_rd(16'h8010, d);
    check("cpu_vram_write_dropped", 16'(d), 16'hA5);

    for (int i = 0; i < 160; i++) cpu_wr(16'(16'hFE00 + i), 8'(i ^ 'hA5));
    PPU_MODE = 2'd2;
    cpu_wr(16'hFE00, 8'h55);
    cpu_rd(16'hFE00, d);
    check("cpu_oam_locked_scan", 16'(d), 16'hFF);
    PPU_MODE = 2'd0;
    cpu_rd(16'hFE00, d);
    check("cpu_oam_write_dropped", 16'(d), 16'hA5);
    cpu_rd(16'hFEA0, d);
    check("cpu_gap_fea0", 16'(d), 16'h00);
    cpu_rd(16'hFEFF, d);
    check("cpu_gap_feff", 16'(d), 16'h00);
    cpu_rd(16'hC000, d);
    check("cpu_unmapped_c000", 16'(d), 16'hFF);
    cpu_rd(16'hFF46, d);
    check("cpu_unmapped_ff46", 16'(d), 16'hFF);

    PPU_ADDR = 16'hFE9F; PPU_MODE = 2'd2;
    @(negedge clk);
    check("ppu_scan_implicit_read", 16'(PPU_DATA), 16'h3A);
    PPU_MODE = 2'd0; PPU_ADDR = 16'h8010;
    @(negedge clk);
    check("ppu_hold", 16'(PPU_DATA), 16'h3A);

`ifdef OAM_DMA_EN
    bus_mix = 1'b0;
    cpu_wr(16'hFF46, 8'hC1);
    run_dma(n, rds, first, last);
    check("dma_c1_active_cycles", 16'(n), 16'd162);
    check("dma_c1_bus_reads", 16'(rds), 16'd160);
    check("dma_c1_first_addr", first, 16'hC100);
    check("dma_c1_last_addr", last, 16'hC19F);
    ppu_rd(16'hFE9F, d);
    check("dma_c1_oam159_after_fall", 16'(d), 16'hA3);
    for (int i = 0; i < 160; i++) begin
      ppu_rd(16'(16'hFE00 + i), d);
      check("dma_c1_oam", 16'(d), 16'(i ^ 'h3C));
    end

    bus_mix = 1'b1; PPU_ADDR = 16'hFE10; PPU_MODE = 2'd2;
    cpu_wr(16'hFF46, 8'hC0);
    repeat (51) @(negedge clk);
    check("dma_c0_idx50_addr", DMA_BUS_ADDR, 16'hC032);
    check("ppu_oam_during_dma", 16'(PPU_DATA), 16'hFF);
    cpu_wr(16'hFF46, 8'hD0);
    run_dma(n, rds, first, last);
    check("dma_restart_active_cycles", 16'(n), 16'd162);
    check("dma_restart_first_addr", first, 16'hD000);
    check("dma_restart_last_addr", last, 16'hD09F);
    PPU_MODE = 2'd0;
    ppu_rd(16'hFE0A, d);
    check("dma_d0_oam10", 16'(d), 16'hDA);
    ppu_rd(16'hFE9F, d);
    check("dma_d0_oam159", 16'(d), 16'h4F);

    cpu_wr(16'hFF46, 8'h12);
    repeat (81) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("dma_abort_active", 16'(DMA_ACTIVE), 16'h0);
    check("dma_abort_bus_rd", 16'(DMA_BUS_RD), 16'h0);
    ppu_rd(16'hFE03, d);
    check("dma_abort_oam3", 16'(d), 16'h11);
    ppu_rd(16'hFE4E, d);
    check("dma_abort_oam78", 16'(d), 16'h5C);
    ppu_rd(16'hFE50, d);
    check("dma_abort_oam80", 16'(d), 16'h80);
    ppu_rd(16'hFE9F, d);
    check("dma_abort_oam159", 16'(d), 16'h4F);
`else
    cpu_wr(16'hFF46, 8'hC1);
    check("nodma_active", 16'(DMA_ACTIVE), 16'h0);
    @(negedge clk);
    check("nodma_bus_rd", 16'(DMA_BUS_RD), 16'h0);
    check("nodma_bus_addr", DMA_BUS_ADDR, 16'h0);
    cpu_rd(16'hFE05, d);
    check("nodma_oam_unchanged", 16'(d), 16'hA0);
    ppu_rd(16'hFE05, d);
    check("nodma_ppu_oam", 16'(d), 16'hA0);
`endif

    repeat (2) @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
